// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants for the PS/2 keyboard receiver
package ps2_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_BUSY      = 3;
  localparam int STAT_PERR_LSB  = 8;
  localparam int STAT_FERR_LSB  = 16;
  localparam int STAT_LEVEL_LSB = 24;

  localparam int ENTRY_W = 10;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/ps2_sync_fifo.sv
// rtl/ps2_sync_fifo.sv - first-word fall-through FIFO, storage not reset
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rd_en, wr_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign level = cnt_q;
  assign dout  = empty ? '0 : mem_q[rp_q];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign rd_en = rd & ~empty;
  assign wr_en = wr & (~full | rd_en);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (wr_en) wp_d = wp_q + 1'b1;
    if (rd_en) rp_d = rp_q + 1'b1;
    if (wr_en && !rd_en) cnt_d = cnt_q + 1'b1;
    else if (!wr_en && rd_en) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver delivering tagged set-2 scan codes via FIFO
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_c,
  input  logic        ps2_d,
  input  logic        fifo_rd,
  input  logic        err_clr,
  output logic [31:0] status,
  output logic [31:0] data
);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    CNT_LAST = 4'(FILT_LEN - 1);

  logic c_s1_q, c_s2_q, d_s1_q, d_s2_q;
  logic [FILT_LEN-1:0] d_dly_q;
  logic [3:0] c_cnt_q, c_cnt_d;
  logic filt_q, filt_d, strobe, bit_in;

  logic [1:0]          state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                ext_q, ext_d, brk_q, brk_d;
  logic [7:0]          perr_q, perr_d, ferr_q, ferr_d;
  logic                ovf_q, ovf_d;
  logic                push_q, push_d;
  logic [ENTRY_W-1:0]  push_data_q, push_data_d;
  logic                perr_ev, ferr_ev, frame_ok;

  logic [ENTRY_W-1:0]  fifo_dout;
  logic                fifo_empty, fifo_full;
  logic [FIFO_AW:0]    fifo_level;

  // Filtered clock flips only once FILT_LEN consecutive synced samples disagree with it.
  always_comb begin
    c_cnt_d = c_cnt_q;
    filt_d  = filt_q;
    if (c_s2_q == filt_q) c_cnt_d = '0;
    else if (c_cnt_q == CNT_LAST) begin
      c_cnt_d = '0;
      filt_d  = c_s2_q;
    end else c_cnt_d = c_cnt_q + 4'd1;
  end

  assign strobe = filt_q & ~filt_d;
  assign bit_in = d_dly_q[FILT_LEN-1];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = '0;
    ext_d       = ext_q;
    brk_d       = brk_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    perr_ev     = 1'b0;
    ferr_ev     = 1'b0;
    frame_ok    = 1'b0;

    if (state_q != ST_IDLE && !strobe) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        ferr_ev = 1'b1;
        tmo_d   = '0;
      end
    end

    if (strobe) begin
      case (state_q)
        ST_IDLE: if (!bit_in) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          par_d     = 1'b0;
        end
        ST_DATA: begin
          shift_d   = {bit_in, shift_q[7:1]};
          par_d     = par_q ^ bit_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = par_q ^ bit_in;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (!par_q) perr_ev = 1'b1;
          else if (!bit_in) ferr_ev = 1'b1;
          else frame_ok = 1'b1;
        end
      endcase
    end

    if (frame_ok) begin
      if (shift_q == PS2_EXT) ext_d = 1'b1;
      else if (shift_q == PS2_BRK) brk_d = 1'b1;
      else begin
        push_d      = 1'b1;
        push_data_d = {ext_q, brk_q, shift_q};
        ext_d       = 1'b0;
        brk_d       = 1'b0;
      end
    end
    if (perr_ev || ferr_ev) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end

    perr_d = perr_ev ? sat_inc(perr_q) : perr_q;
    ferr_d = ferr_ev ? sat_inc(ferr_q) : ferr_q;
    ovf_d  = ovf_q | (push_q & fifo_full & ~fifo_rd);
    if (err_clr) begin
      perr_d = '0;
      ferr_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_s1_q      <= 1'b1;
      c_s2_q      <= 1'b1;
      d_s1_q      <= 1'b1;
      d_s2_q      <= 1'b1;
      d_dly_q     <= '1;
      c_cnt_q     <= '0;
      filt_q      <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      perr_q      <= '0;
      ferr_q      <= '0;
      ovf_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      c_s1_q      <= ps2_c;
      c_s2_q      <= c_s1_q;
      d_s1_q      <= ps2_d;
      d_s2_q      <= d_s1_q;
      d_dly_q     <= {d_dly_q[FILT_LEN-2:0], d_s2_q};
      c_cnt_q     <= c_cnt_d;
      filt_q      <= filt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
    end
  end

  ps2_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push_q),
    .rd    (fifo_rd),
    .din   (push_data_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_comb begin
    status                           = '0;
    status[STAT_EMPTY]               = fifo_empty;
    status[STAT_FULL]                = fifo_full;
    status[STAT_OVF]                 = ovf_q;
    status[STAT_BUSY]                = (state_q != ST_IDLE);
    status[STAT_PERR_LSB +: 8]       = perr_q;
    status[STAT_FERR_LSB +: 8]       = ferr_q;
    status[STAT_LEVEL_LSB +: 8]      = 8'(fifo_level);
  end

  assign data = {22'd0, fifo_dout};
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Parametrised PS/2 keyboard receiver for host-to-CPU scan-code input.
- Replaces the fixed ASCII-converting receiver: delivers raw set-2 scan codes tagged with make/break and extended flags.
- Adds input synchronisation, clock glitch filtering, start/parity/stop checking, inter-bit timeout and error counters.
- Feeds a configurable-depth FIFO read through the same 32-bit status/data register pair used by the CPU bus.

Parameters:
FILT_LEN, 4, number of consecutive equal samples required before filtered ps2_c changes (2..16)
TIMEOUT_CYC, 100000, max clk cycles between falling edges inside a frame before abort (≥16)
FIFO_DEPTH, 16, FIFO entries, power of two, 2..128
FIFO_AW, clog2(FIFO_DEPTH), derived address width, not overridden

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ps2_c  in  1  PS/2 clock pin, asynchronous
ps2_d  in  1  PS/2 data pin, asynchronous
fifo_rd  in  1  one-cycle pop strobe; ignored when empty
err_clr  in  1  one-cycle strobe: clears overflow flag and both error counters
status  out  32  [0] empty, [1] full, [2] overflow sticky, [3] rx_busy, [7:4] 0, [15:8] parity_err_cnt, [23:16] frame_err_cnt, [31:24] fifo level
data  out  32  [7:0] scan code, [8] brk, [9] ext, [31:10] 0; FIFO head, first-word fall-through

Behaviour:
- Reset (async, rst=1): FSM IDLE, FIFO empty, counters 0, pending flags 0, filtered clock=1, sync flops=1. Outputs: status=32'h0000_0001, data=0.
- Input sync: ps2_c and ps2_d each pass through 2 flops.
- Glitch filter: filtered clock takes the synced value only after FILT_LEN consecutive equal samples. A 1→0 transition of the filtered clock is a sample strobe.
- Data path: synced ps2_d is delayed to match filter latency, so it is sampled at the strobe.
- FSM, one step per strobe:
  - IDLE: start bit 0 → DATA; start bit 1 → stay IDLE, no error.
  - DATA: 8 bits, LSB first → PARITY.
  - PARITY → STOP.
  - STOP: frame complete, return to IDLE.
- rx_busy = (state != IDLE).
- Checks at STOP:
  - Parity must be odd over data+parity bit; otherwise parity_err_cnt++ and frame discarded.
  - Stop bit must be 1; otherwise frame_err_cnt++ and frame discarded.
  - If both fail, only parity_err_cnt increments.
- Timeout: in any non-IDLE state, a cycle counter resets on each strobe. Reaching TIMEOUT_CYC → IDLE, frame_err_cnt++, partial frame discarded.
- Counters: 8-bit, saturate at 255.
- Prefix decode on valid frames:
  - 8'hE0 sets pending ext, no push.
  - 8'hF0 sets pending brk, no push.
  - Any other code is pushed as {ext,brk,code}, then both pending flags clear.
  - Any error or timeout clears pending flags.
- Latency: stop-bit strobe at cycle N → FIFO write at N+1 → empty=0 and data valid at N+2.
- FIFO rules:
  - Push while full (no simultaneous pop): drop entry, set overflow.
  - Push and pop in the same cycle while full: both accepted, level unchanged.
  - Push and pop in the same cycle while empty: push accepted, pop ignored.
  - Pop advances head; data reflects the new head next cycle.
  - data=0 when empty.
- err_clr and an error event in the same cycle: clear wins; the counter ends at 0.
- Pointers wrap modulo FIFO_DEPTH. Level = 0..FIFO_DEPTH, zero-extended into status[31:24].

Decomposition:
- Package ps2_pkg holds:
  - constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - FSM state enum {IDLE, DATA, PARITY, STOP};
  - status bit-position constants;
  - FIFO entry width constant = 10.
- One sub-module: ps2_sync_fifo.
  - Parameters: width, depth.
  - Ports: wr, rd, din, dout, empty, full, level.
  - Behaviour: FWFT, dual-pointer, no reset of storage.

Test Plan:
Bench settings: FILT_LEN=4, TIMEOUT_CYC=200, FIFO_DEPTH=4, PS/2 bit period 40 clk.
1. Frame 8'h1C, correct odd parity, stop=1 → data=32'h0000_001C two cycles after the stop strobe; status[0] 1→0; level=1.
2. Sequence E0, F0, 75 → single entry data=32'h0000_0375; the next frame 1C pushes 32'h0000_001C with flags cleared.
3. Frame 8'h1C with wrong parity, then a frame with stop=0 → FIFO stays empty; status[15:8]=1, status[23:16]=1; err_clr → both 0.
4. 1-cycle and 3-cycle low glitches on ps2_c while idle and mid-frame → no extra bits; the following frame decodes correctly.
5. Send 4 start+3 data bits, then hold the clock high for 250 cycles → rx_busy 1→0 at timeout; frame_err_cnt=1; a clean 8'h16 afterwards decodes as 32'h0000_0016.
6. Push 5 codes without reading → full=1, overflow=1, level=4, first 4 codes retained. Pop with a push in the same cycle while full → level stays 4. Assert rst mid-frame → status=32'h0000_0001 immediately.
